// File: rtl/forward_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : forward_hazard_ctrl
// Description : EX-stage operand forwarding selects, load-use stall and
//               taken-branch flush control for the five-stage MIPS pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module forward_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] idRs,
    input  logic [REG_AW-1:0] idRt,
    input  logic              idUsesRs,
    input  logic              idUsesRt,
    input  logic [REG_AW-1:0] idRd,
    input  logic              idRegWrite,
    input  logic              idMemRead,
    input  logic              exBranchTaken,
    output logic [1:0]        fwdASel,
    output logic [1:0]        fwdBSel,
    output logic              pcWrite,
    output logic              ifIdWrite,
    output logic              ifIdFlush,
    output logic              idExFlush,
    output logic [CNT_W-1:0]  stallCnt,
    output logic [CNT_W-1:0]  flushCnt
);

    localparam logic [1:0]        c_SEL_IDEX  = 2'b00;
    localparam logic [1:0]        c_SEL_EXMEM = 2'b01;
    localparam logic [1:0]        c_SEL_MEMWB = 2'b10;
    localparam logic [REG_AW-1:0] c_REG_ZERO  = '0;
    localparam logic [CNT_W-1:0]  c_CNT_ONE   = CNT_W'(1);

    // Shadow copy of the destination/source information held in the pipeline
    logic [REG_AW-1:0] r_idex_rs;
    logic [REG_AW-1:0] r_idex_rt;
    logic              r_idex_uses_rs;
    logic              r_idex_uses_rt;
    logic [REG_AW-1:0] r_idex_rd;
    logic              r_idex_reg_write;
    logic              r_idex_mem_read;
    logic [REG_AW-1:0] r_exmem_rd;
    logic              r_exmem_reg_write;
    logic [REG_AW-1:0] r_memwb_rd;
    logic              r_memwb_reg_write;

    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_load_use;
    logic              w_stall;
    logic              w_bubble;
    logic              w_exmem_live;
    logic              w_memwb_live;

    assign w_exmem_live = r_exmem_reg_write && (r_exmem_rd != c_REG_ZERO);
    assign w_memwb_live = r_memwb_reg_write && (r_memwb_rd != c_REG_ZERO);

    // EX/MEM holds the younger result, so it wins over MEM/WB
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              uses
    );
        logic [1:0] sel;
        sel = c_SEL_IDEX;
        if (uses) begin
            if (w_exmem_live && (r_exmem_rd == src))
                sel = c_SEL_EXMEM;
            else if (w_memwb_live && (r_memwb_rd == src))
                sel = c_SEL_MEMWB;
        end
        return sel;
    endfunction

    assign w_load_use = r_idex_mem_read && (r_idex_rd != c_REG_ZERO) &&
                        ((idUsesRs && (r_idex_rd == idRs)) ||
                         (idUsesRt && (r_idex_rd == idRt)));
    assign w_stall    = w_load_use && !exBranchTaken;
    assign w_bubble   = w_load_use || exBranchTaken;

    always_comb begin
        fwdASel   = fwd_sel(r_idex_rs, r_idex_uses_rs);
        fwdBSel   = fwd_sel(r_idex_rt, r_idex_uses_rt);
        pcWrite   = 1'b1;
        ifIdWrite = 1'b1;
        ifIdFlush = 1'b0;
        idExFlush = 1'b0;
        // Reset forces the free-running defaults regardless of a pending branch
        if (!rst) begin
            if (exBranchTaken) begin
                ifIdFlush = 1'b1;
                idExFlush = 1'b1;
            end else if (w_load_use) begin
                pcWrite   = 1'b0;
                ifIdWrite = 1'b0;
                idExFlush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idex_rs         <= c_REG_ZERO;
            r_idex_rt         <= c_REG_ZERO;
            r_idex_uses_rs    <= 1'b0;
            r_idex_uses_rt    <= 1'b0;
            r_idex_rd         <= c_REG_ZERO;
            r_idex_reg_write  <= 1'b0;
            r_idex_mem_read   <= 1'b0;
            r_exmem_rd        <= c_REG_ZERO;
            r_exmem_reg_write <= 1'b0;
            r_memwb_rd        <= c_REG_ZERO;
            r_memwb_reg_write <= 1'b0;
        end else begin
            r_memwb_rd        <= r_exmem_rd;
            r_memwb_reg_write <= r_exmem_reg_write;
            r_exmem_rd        <= r_idex_rd;
            r_exmem_reg_write <= r_idex_reg_write;
            if (w_bubble) begin
                r_idex_rs        <= c_REG_ZERO;
                r_idex_rt        <= c_REG_ZERO;
                r_idex_uses_rs   <= 1'b0;
                r_idex_uses_rt   <= 1'b0;
                r_idex_rd        <= c_REG_ZERO;
                r_idex_reg_write <= 1'b0;
                r_idex_mem_read  <= 1'b0;
            end else begin
                r_idex_rs        <= idRs;
                r_idex_rt        <= idRt;
                r_idex_uses_rs   <= idUsesRs;
                r_idex_uses_rt   <= idUsesRt;
                r_idex_rd        <= idRd;
                r_idex_reg_write <= idRegWrite;
                r_idex_mem_read  <= idMemRead;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall)
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            if (exBranchTaken)
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
        end
    end

    assign stallCnt = r_stall_cnt;
    assign flushCnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_forward_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_forward_hazard_ctrl
// Description : Directed self-checking bench for forward_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_forward_hazard_ctrl;

    localparam int c_REG_AW = 5;
    localparam int c_CNT_W  = 4;

    logic                clk;
    logic                rst;
    logic [c_REG_AW-1:0] idRs;
    logic [c_REG_AW-1:0] idRt;
    logic                idUsesRs;
    logic                idUsesRt;
    logic [c_REG_AW-1:0] idRd;
    logic                idRegWrite;
    logic                idMemRead;
    logic                exBranchTaken;
    logic [1:0]          fwdASel;
    logic [1:0]          fwdBSel;
    logic                pcWrite;
    logic                ifIdWrite;
    logic                ifIdFlush;
    logic                idExFlush;
    logic [c_CNT_W-1:0]  stallCnt;
    logic [c_CNT_W-1:0]  flushCnt;

    int checks;
    int errors;

    forward_hazard_ctrl #(.REG_AW(c_REG_AW), .CNT_W(c_CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .idRs         (idRs),
        .idRt         (idRt),
        .idUsesRs     (idUsesRs),
        .idUsesRt     (idUsesRt),
        .idRd         (idRd),
        .idRegWrite   (idRegWrite),
        .idMemRead    (idMemRead),
        .exBranchTaken(exBranchTaken),
        .fwdASel      (fwdASel),
        .fwdBSel      (fwdBSel),
        .pcWrite      (pcWrite),
        .ifIdWrite    (ifIdWrite),
        .ifIdFlush    (ifIdFlush),
        .idExFlush    (idExFlush),
        .stallCnt     (stallCnt),
        .flushCnt     (flushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] rd,
                         input logic rw, input logic mr);
        idRs = rs; idRt = rt; idUsesRs = urs; idUsesRt = urt;
        idRd = rd; idRegWrite = rw; idMemRead = mr;
        #1;
    endtask

    task automatic drive_nop();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        exBranchTaken = 1'b0;
        drive_nop();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Control word order: {pcWrite, ifIdWrite, ifIdFlush, idExFlush}
    task automatic test_reset();
        exBranchTaken = 1'b1;
        drive(5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1);
        rst = 1'b1;
        #2;
        checks++;
        if ({pcWrite, ifIdWrite, ifIdFlush, idExFlush} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=1100", {pcWrite, ifIdWrite, ifIdFlush, idExFlush});
        end
        checks++;
        if ({fwdASel, fwdBSel, stallCnt, flushCnt} !== 12'h000) begin
            errors++;
            $display("FAIL reset_sel_cnt got=%h exp=000", {fwdASel, fwdBSel, stallCnt, flushCnt});
        end
        tick();
        rst = 1'b0;
        exBranchTaken = 1'b0;
        drive_nop();
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3,$1,$2
        tick();
        drive(5'd3, 5'd4, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // sub $6,$3,$4
        checks++;
        if ({pcWrite, ifIdWrite, ifIdFlush, idExFlush} !== 4'b1100) begin
            errors++;
            $display("FAIL b2b_nostall got=%b exp=1100", {pcWrite, ifIdWrite, ifIdFlush, idExFlush});
        end
        tick();
        drive_nop();
        checks++;
        if ({fwdASel, fwdBSel} !== 4'b0100) begin
            errors++;
            $display("FAIL b2b_fwd got=%b exp=0100", {fwdASel, fwdBSel});
        end
        checks++;
        if (stallCnt !== 4'd0) begin
            errors++;
            $display("FAIL b2b_stallcnt got=%0d exp=0", stallCnt);
        end
    endtask

    task automatic test_priority();
        do_reset();
        drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        drive(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);   // addi $3,$3
        tick();
        drive(5'd7, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        tick();
        drive_nop();
        checks++;
        if ({fwdASel, fwdBSel} !== 4'b0001) begin
            errors++;
            $display("FAIL dist2_double got=%b exp=0001", {fwdASel, fwdBSel});
        end
        do_reset();
        drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        drive_nop();
        tick();
        drive(5'd7, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        tick();
        drive_nop();
        checks++;
        if ({fwdASel, fwdBSel} !== 4'b0010) begin
            errors++;
            $display("FAIL dist2_memwb got=%b exp=0010", {fwdASel, fwdBSel});
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);   // lw $5
        tick();
        drive(5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        checks++;
        if ({pcWrite, ifIdWrite, ifIdFlush, idExFlush} !== 4'b0001) begin
            errors++;
            $display("FAIL lu_stall got=%b exp=0001", {pcWrite, ifIdWrite, ifIdFlush, idExFlush});
        end
        tick();
        checks++;
        if ({pcWrite, ifIdWrite, ifIdFlush, idExFlush} !== 4'b1100) begin
            errors++;
            $display("FAIL lu_release got=%b exp=1100", {pcWrite, ifIdWrite, ifIdFlush, idExFlush});
        end
        checks++;
        if (stallCnt !== 4'd1) begin
            errors++;
            $display("FAIL lu_stallcnt got=%0d exp=1", stallCnt);
        end
        tick();
        drive_nop();
        checks++;
        if ({fwdASel, fwdBSel} !== 4'b1000) begin
            errors++;
            $display("FAIL lu_fwd got=%b exp=1000", {fwdASel, fwdBSel});
        end
    endtask

    task automatic test_no_stall_cases();
        do_reset();
        drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);   // lw $0
        tick();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        checks++;
        if ({pcWrite, ifIdWrite, ifIdFlush, idExFlush} !== 4'b1100) begin
            errors++;
            $display("FAIL r0_nostall got=%b exp=1100", {pcWrite, ifIdWrite, ifIdFlush, idExFlush});
        end
        tick();
        drive_nop();
        checks++;
        if ({fwdASel, fwdBSel} !== 4'b0000) begin
            errors++;
            $display("FAIL r0_nofwd got=%b exp=0000", {fwdASel, fwdBSel});
        end
        do_reset();
        drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);   // lw $5
        tick();
        drive(5'd5, 5'd5, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
        checks++;
        if ({pcWrite, ifIdWrite, ifIdFlush, idExFlush} !== 4'b1100) begin
            errors++;
            $display("FAIL nouse_nostall got=%b exp=1100", {pcWrite, ifIdWrite, ifIdFlush, idExFlush});
        end
        tick();
        drive_nop();
        checks++;
        if ({fwdASel, fwdBSel, stallCnt} !== 8'h00) begin
            errors++;
            $display("FAIL nouse_nofwd got=%h exp=00", {fwdASel, fwdBSel, stallCnt});
        end
    endtask

    task automatic test_branch_over_load_use();
        do_reset();
        drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        exBranchTaken = 1'b1;
        drive(5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        checks++;
        if ({pcWrite, ifIdWrite, ifIdFlush, idExFlush} !== 4'b1111) begin
            errors++;
            $display("FAIL br_ctrl got=%b exp=1111", {pcWrite, ifIdWrite, ifIdFlush, idExFlush});
        end
        tick();
        exBranchTaken = 1'b0;
        drive_nop();
        checks++;
        if ({flushCnt, stallCnt} !== 8'h10) begin
            errors++;
            $display("FAIL br_counts got=%h exp=10", {flushCnt, stallCnt});
        end
        checks++;
        if ({pcWrite, ifIdWrite, ifIdFlush, idExFlush} !== 4'b1100) begin
            errors++;
            $display("FAIL br_oneshot got=%b exp=1100", {pcWrite, ifIdWrite, ifIdFlush, idExFlush});
        end
    endtask

    task automatic one_stall();
        drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_wrap_and_async_reset();
        do_reset();
        for (int i = 0; i < 15; i++) one_stall();
        checks++;
        if (stallCnt !== 4'd15) begin
            errors++;
            $display("FAIL wrap_reach15 got=%0d exp=15", stallCnt);
        end
        one_stall();
        checks++;
        if (stallCnt !== 4'd0) begin
            errors++;
            $display("FAIL wrap_zero got=%0d exp=0", stallCnt);
        end
        for (int i = 0; i < 15; i++) one_stall();
        checks++;
        if (stallCnt !== 4'd15) begin
            errors++;
            $display("FAIL wrap_back15 got=%0d exp=15", stallCnt);
        end
        drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
        checks++;
        if ({pcWrite, ifIdWrite, ifIdFlush, idExFlush} !== 4'b0001) begin
            errors++;
            $display("FAIL midstall_pre got=%b exp=0001", {pcWrite, ifIdWrite, ifIdFlush, idExFlush});
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({pcWrite, ifIdWrite, ifIdFlush, idExFlush, fwdASel, fwdBSel, stallCnt, flushCnt} !== 16'hC000) begin
            errors++;
            $display("FAIL async_reset got=%h exp=c000",
                     {pcWrite, ifIdWrite, ifIdFlush, idExFlush, fwdASel, fwdBSel, stallCnt, flushCnt});
        end
        #2;
        rst = 1'b0;
        drive_nop();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        exBranchTaken = 1'b0;
        idRs = '0; idRt = '0; idUsesRs = 1'b0; idUsesRt = 1'b0;
        idRd = '0; idRegWrite = 1'b0; idMemRead = 1'b0;
        tick();
        test_reset();
        test_back_to_back();
        test_priority();
        test_load_use();
        test_no_stall_cases();
        test_branch_over_load_use();
        test_wrap_and_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
